// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the load/store port.
// Define MEM_ARB_RR_EN to break request ties round-robin instead of always favouring data.
module mem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [63:0]       d_wdata,
   input  logic [7:0]        d_be,
   output logic [63:0]       d_rdata,
   output logic              d_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_be,
   input  logic [63:0]       mem_rdata,
   output logic              busy
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;
   localparam logic [3:0] LAT     = 4'(RD_LATENCY);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_own_d;
   logic [ADDR_W-1:0] r_addr;
   logic [63:0]       r_wdata;
   logic [7:0]        r_be;
   logic [31:0]       r_i_rdata;
   logic [63:0]       r_d_rdata;
   logic              w_any_req;
   logic              w_grant_d;

   assign w_any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
   // r_last_d remembers which port won the previous grant; reset means "instruction"
   logic r_last_d;

   always_comb begin
      w_grant_d = d_req;
      if (d_req && i_req) begin
         w_grant_d = ~r_last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_d <= 1'b0;
      end else if (r_state == S_IDLE && w_any_req) begin
         r_last_d <= w_grant_d;
      end
   end
`else
   assign w_grant_d = d_req;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_own_d   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_own_d <= w_grant_d;
                  if (w_grant_d) begin
                     r_addr  <= d_addr;
                     r_wdata <= d_wdata;
                     r_be    <= d_be;
                  end else begin
                     r_addr <= i_addr;
                  end
                  if (w_grant_d && d_we) begin
                     r_state <= S_WRITE;
                  end else begin
                     r_state <= S_READ;
                     r_cnt   <= LAT;
                  end
               end
            end
            S_READ: begin
               // READ spans RD_LATENCY+1 cycles; data is taken on the cycle the count reaches zero
               if (r_cnt == 4'd0) begin
                  if (r_own_d) begin
                     r_d_rdata <= mem_rdata;
                  end else begin
                     r_i_rdata <= r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                  end
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_WRITE: begin
               r_state <= S_IDLE;
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_be    = r_be;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;
   assign mem_we    = (r_state == S_WRITE);
   assign busy      = (r_state != S_IDLE);
   assign d_ack     = (r_state == S_WRITE) | ((r_state == S_RESP) & r_own_d);
   assign i_ack     = (r_state == S_RESP) & ~r_own_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int LAT = 1;
`ifdef MEM_ARB_RR_EN
   localparam bit RR  = 1'b1;
   localparam int EI  = 7;
   localparam int ED2 = 11;
`else
   localparam bit RR  = 1'b0;
   localparam int EI  = 11;
   localparam int ED2 = 7;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, i_req3, d_req3;
   logic [63:0] i_addr, d_addr, d_wdata;
   logic [7:0]  d_be;
   logic [31:0] i_rdata, i_rdata3;
   logic        i_ack, d_ack, mem_we, busy;
   logic        i_ack3, d_ack3, mem_we3, busy3;
   logic [63:0] d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [63:0] d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
   logic [7:0]  mem_be, mem_be3;
   logic [63:0] memarr [32];
   logic [63:0] rd_q, mem_rdata_drv;
   logic        use_mem;

   int n_pass = 0;
   int n_total = 0;

   // reference model state (transaction level: start cycle, ack cycle, owner)
   int          m_start, m_ack, m_free;
   bit          m_own_d, m_store, m_last_d, pend_i, pend_d, win_d;
   logic [63:0] m_exp_addr, m_exp_rd, m_exp_wdata, word;
   logic [7:0]  m_exp_be;

   always #5 clk = ~clk;

   always @(posedge clk) rd_q <= memarr[mem_addr[7:3]];
   assign mem_rdata = use_mem ? rd_q : mem_rdata_drv;

   mem_port_arbiter #(.ADDR_W(64), .RD_LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(64), .RD_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .i_req(i_req3), .i_addr(i_addr), .i_rdata(i_rdata3), .i_ack(i_ack3),
      .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata3), .d_ack(d_ack3),
      .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_be(mem_be3),
      .mem_rdata(mem_rdata3), .busy(busy3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      for (int k = 0; k < 32; k++) memarr[k] = {$urandom(), $urandom()};
      reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_req3 = 0; d_req3 = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
      mem_rdata_drv = '0; mem_rdata3 = '0; use_mem = 1'b1;
      tick(); tick();
      chk("rst_busy", busy, 0);       chk("rst_i_ack", i_ack, 0);
      chk("rst_d_ack", d_ack, 0);     chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", mem_be, 0);   chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      reset = 1'b0;

      // lone fetch, upper word selected by addr[2]
      use_mem = 1'b0; mem_rdata_drv = 64'hBAD0_BAD0_BAD0_BAD0;
      i_addr = 64'h104; i_req = 1'b1;
      tick();
      chk("fetch_mem_addr", mem_addr, 64'h104); chk("fetch_busy_c1", busy, 1);
      chk("fetch_ack_c1", i_ack, 0);
      tick();
      mem_rdata_drv = 64'h1111_2222_3333_4444;
      chk("fetch_ack_c2", i_ack, 0);
      tick();
      mem_rdata_drv = 64'hBAD1_BAD1_BAD1_BAD1;
      chk("fetch_ack_c3", i_ack, 1); chk("fetch_rdata", i_rdata, 64'h1111_2222);
      chk("fetch_dack_c3", d_ack, 0);
      tick();
      i_req = 1'b0;
      chk("fetch_busy_c4", busy, 0); chk("fetch_ack_c4", i_ack, 0);

      // lone store
      use_mem = 1'b1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h40; d_wdata = 64'hDEAD; d_be = 8'h0F;
      tick();
      chk("st_we_c1", mem_we, 1); chk("st_addr", mem_addr, 64'h40);
      chk("st_be", mem_be, 8'h0F); chk("st_wdata", mem_wdata, 64'hDEAD);
      chk("st_dack_c1", d_ack, 1); chk("st_iack_c1", i_ack, 0);
      tick();
      d_req = 1'b0;
      chk("st_we_c2", mem_we, 0); chk("st_dack_c2", d_ack, 0); chk("st_busy_c2", busy, 0);

      // tie on loads after reset: data first, fetch served from the next IDLE
      reset = 1'b1; tick(); reset = 1'b0;
      d_we = 1'b0; i_addr = 64'h0; d_addr = 64'h80; i_req = 1'b1; d_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 4) d_req = 1'b0;
         chk("tieA_d_ack", d_ack, (c == 3));
         chk("tieA_i_ack", i_ack, (c == 7));
         if (c == 3) chk("tieA_d_rdata", d_rdata, memarr[16]);
         if (c == 7) chk("tieA_i_rdata", i_rdata, {32'h0, memarr[0][31:0]});
      end

      // second pair of ties: data re-requests right after its ack
      i_addr = 64'h8; d_addr = 64'h88; d_req = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 4) d_addr = 64'h90;
         if (c == 8) begin
            if (RR) i_req = 1'b0;
            else d_req = 1'b0;
         end
         if (c == 12) begin
            if (RR) d_req = 1'b0;
            else i_req = 1'b0;
         end
         chk("tieB_i_ack", i_ack, (c == EI));
         chk("tieB_d_ack", d_ack, (c == 3 || c == ED2));
         if (c == 3) chk("tieB_d_rdata1", d_rdata, memarr[17]);
         if (c == ED2) chk("tieB_d_rdata2", d_rdata, memarr[18]);
         if (c == EI) chk("tieB_i_rdata", i_rdata, {32'h0, memarr[1][31:0]});
      end

      // reset in cycle 1 of a load
      d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
      tick();
      chk("rstmid_busy_c1", busy, 1); chk("rstmid_we_c1", mem_we, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0; d_req = 1'b0;
      chk("rstmid_busy_c2", busy, 0); chk("rstmid_addr_c2", mem_addr, 0);
      for (int c = 2; c <= 6; c++) begin
         chk("rstmid_d_ack", d_ack, 0); chk("rstmid_we", mem_we, 0);
         tick();
      end

      // RD_LATENCY=3 fetch on the second instance
      i_addr = 64'h10; i_req3 = 1'b1; mem_rdata3 = 64'hBAD2_BAD2_BAD2_BAD2;
      for (int c = 1; c <= 6; c++) begin
         tick();
         mem_rdata3 = (c == 4) ? 64'hAAAA_BBBB_CCCC_DDDD : (64'hBAD3_0000_BAD3_0000 ^ 64'(c));
         if (c == 6) i_req3 = 1'b0;
         chk("l3_i_ack", i_ack3, (c == 5));
         chk("l3_d_ack_we", {d_ack3, mem_we3}, 0);
         if (c == 1) chk("l3_mem_addr", mem_addr3, 64'h10);
         if (c == 5) chk("l3_i_rdata", i_rdata3, 64'hCCCC_DDDD);
         if (c == 6) chk("l3_busy_c6", busy3, 0);
      end
      chk("l3_hold_wdata", mem_wdata3, 0); chk("l3_hold_be", mem_be3, 0);
      chk("l3_hold_d_rdata", d_rdata3, 0);

      // randomized traffic against the transaction-level model
      reset = 1'b1; tick(); reset = 1'b0;
      i_req = 0; d_req = 0; pend_i = 0; pend_d = 0;
      m_start = -100; m_ack = -100; m_free = 0; m_last_d = 0;
      m_own_d = 0; m_store = 0;
      m_exp_addr = '0; m_exp_rd = '0; m_exp_wdata = '0; m_exp_be = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (m_ack == cyc - 1) begin
            if (m_own_d) begin pend_d = 0; d_req = 0; end
            else begin pend_i = 0; i_req = 0; end
         end
         if (!pend_i && $urandom_range(0, 2) == 0) begin
            pend_i = 1; i_req = 1; i_addr = 64'($urandom_range(0, 255));
         end
         if (!pend_d && $urandom_range(0, 2) == 0) begin
            pend_d = 1; d_req = 1; d_addr = 64'($urandom_range(0, 255));
            d_we = 1'($urandom_range(0, 1)); d_wdata = {$urandom(), $urandom()};
            d_be = 8'($urandom_range(0, 255));
         end
         chk("rnd_busy", busy, (cyc > m_start && cyc <= m_ack));
         chk("rnd_i_ack", i_ack, (cyc == m_ack && !m_own_d));
         chk("rnd_d_ack", d_ack, (cyc == m_ack && m_own_d));
         chk("rnd_mem_we", mem_we, (cyc == m_ack && m_store));
         if (cyc == m_start + 1) chk("rnd_mem_addr", mem_addr, m_exp_addr);
         if (cyc == m_ack) begin
            if (m_store) begin
               chk("rnd_wdata", mem_wdata, m_exp_wdata); chk("rnd_be", mem_be, m_exp_be);
            end else if (m_own_d) begin
               chk("rnd_d_rdata", d_rdata, m_exp_rd);
            end else begin
               chk("rnd_i_rdata", i_rdata, m_exp_rd);
            end
         end
         if (cyc >= m_free && (pend_i || pend_d)) begin
            win_d = pend_d && (!pend_i || (RR ? !m_last_d : 1'b1));
            m_last_d = win_d;
            m_own_d = win_d;
            m_store = win_d && d_we;
            m_start = cyc;
            m_ack = cyc + (m_store ? 1 : LAT + 2);
            m_free = m_ack + 1;
            m_exp_addr = win_d ? d_addr : i_addr;
            m_exp_wdata = d_wdata;
            m_exp_be = d_be;
            word = memarr[m_exp_addr[7:3]];
            if (win_d) m_exp_rd = word;
            else m_exp_rd = m_exp_addr[2] ? {32'h0, word[63:32]} : {32'h0, word[31:0]};
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
